// File: rtl/phase_sweep_ctrl.sv
// NCO frequency-sweep sequencer: steps the phase increment, waits for the filters to settle,
// integrates decimated I/Q per step and hands each step's sums downstream over valid/ready.
module phase_sweep_ctrl #(
  parameter int unsigned PW    = 19,
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 24,
  parameter int unsigned ACC_W = 32
) (
  input  logic                    sys_clk,
  input  logic                    i_reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PW-1:0]           cfg_start_inc,
  input  logic [PW-1:0]           cfg_step_inc,
  input  logic [15:0]             cfg_num_steps,
  input  logic [CNT_W-1:0]        cfg_settle,
  input  logic [15:0]             cfg_dwell,
  input  logic                    sample_ce,
  input  logic signed [DW-1:0]    sample_x,
  input  logic signed [DW-1:0]    sample_y,
  output logic [PW-1:0]           phase_inc,
  output logic                    busy,
  output logic                    done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [15:0]             res_index,
  output logic signed [ACC_W-1:0] res_sum_x,
  output logic signed [ACC_W-1:0] res_sum_y
);

  typedef enum logic [1:0] {StIdle, StSettle, StAccum, StReport} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [PW-1:0]     step_inc_q, step_inc_d;
  logic [15:0]       num_steps_q, num_steps_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [15:0]       dwell_q, dwell_d;
  logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [15:0]       idx_q, idx_d;
  logic [15:0]       smp_cnt_q, smp_cnt_d;
  logic [ACC_W-1:0]  acc_x_q, acc_x_d;
  logic [ACC_W-1:0]  acc_y_q, acc_y_d;
  logic              done_q, done_d;

  logic [ACC_W-1:0]  ext_x, ext_y;
  logic [15:0]       smp_cnt_inc;

  assign ext_x       = {{(ACC_W-DW){sample_x[DW-1]}}, sample_x};
  assign ext_y       = {{(ACC_W-DW){sample_y[DW-1]}}, sample_y};
  assign smp_cnt_inc = smp_cnt_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    step_inc_d   = step_inc_q;
    num_steps_d  = num_steps_q;
    settle_d     = settle_q;
    dwell_d      = dwell_q;
    settle_cnt_d = settle_cnt_q;
    idx_d        = idx_q;
    smp_cnt_d    = smp_cnt_q;
    acc_x_d      = acc_x_q;
    acc_y_d      = acc_y_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (cfg_num_steps == 16'd0) begin
            done_d = 1'b1;
          end else begin
            step_inc_d   = cfg_step_inc;
            num_steps_d  = cfg_num_steps;
            settle_d     = cfg_settle;
            dwell_d      = (cfg_dwell == 16'd0) ? 16'd1 : cfg_dwell;
            phase_d      = cfg_start_inc;
            idx_d        = 16'd0;
            settle_cnt_d = cfg_settle;
            state_d      = StSettle;
          end
        end
      end
      StSettle: begin
        if (settle_cnt_q == '0) begin
          acc_x_d   = '0;
          acc_y_d   = '0;
          smp_cnt_d = 16'd0;
          state_d   = StAccum;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      StAccum: begin
        if (sample_ce) begin
          acc_x_d   = acc_x_q + ext_x;
          acc_y_d   = acc_y_q + ext_y;
          smp_cnt_d = smp_cnt_inc;
          if (smp_cnt_inc == dwell_q) state_d = StReport;
        end
      end
      StReport: begin
        if (res_ready) begin
          if (idx_q == num_steps_q - 16'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d        = idx_q + 16'd1;
            phase_d      = phase_q + step_inc_q;
            settle_cnt_d = settle_q;
            state_d      = StSettle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort drops any pending result; phase_inc keeps its current value.
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      step_inc_q   <= '0;
      num_steps_q  <= '0;
      settle_q     <= '0;
      dwell_q      <= 16'd1;
      settle_cnt_q <= '0;
      idx_q        <= '0;
      smp_cnt_q    <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      step_inc_q   <= step_inc_d;
      num_steps_q  <= num_steps_d;
      settle_q     <= settle_d;
      dwell_q      <= dwell_d;
      settle_cnt_q <= settle_cnt_d;
      idx_q        <= idx_d;
      smp_cnt_q    <= smp_cnt_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      done_q       <= done_d;
    end
  end

  assign phase_inc = phase_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign res_valid = (state_q == StReport);
  assign res_index = idx_q;
  assign res_sum_x = acc_x_q;
  assign res_sum_y = acc_y_q;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Randomized bench for phase_sweep_ctrl: each sweep is predicted step by step from the
// timing rules (settle+1 cycles, dwell samples, registered handshake) with plain arithmetic.
module tb_phase_sweep_ctrl;

  localparam int unsigned PW = 19;
  localparam int unsigned DW = 16;
  localparam int unsigned CNT_W = 24;
  localparam int unsigned ACC_W = 32;

  logic                    sys_clk = 1'b0;
  logic                    i_reset;
  logic                    start, abort;
  logic [PW-1:0]           cfg_start_inc, cfg_step_inc;
  logic [15:0]             cfg_num_steps;
  logic [CNT_W-1:0]        cfg_settle;
  logic [15:0]             cfg_dwell;
  logic                    sample_ce;
  logic signed [DW-1:0]    sample_x, sample_y;
  logic [PW-1:0]           phase_inc;
  logic                    busy, done, res_valid, res_ready;
  logic [15:0]             res_index;
  logic signed [ACC_W-1:0] res_sum_x, res_sum_y;

  int n_checks = 0;
  int n_errors = 0;

  logic                 fix_en = 1'b0;
  logic signed [DW-1:0] fix_x, fix_y;

  phase_sweep_ctrl #(.PW(PW), .DW(DW), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .sys_clk      (sys_clk),
    .i_reset      (i_reset),
    .start        (start),
    .abort        (abort),
    .cfg_start_inc(cfg_start_inc),
    .cfg_step_inc (cfg_step_inc),
    .cfg_num_steps(cfg_num_steps),
    .cfg_settle   (cfg_settle),
    .cfg_dwell    (cfg_dwell),
    .sample_ce    (sample_ce),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .phase_inc    (phase_inc),
    .busy         (busy),
    .done         (done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_index    (res_index),
    .res_sum_x    (res_sum_x),
    .res_sum_y    (res_sum_y)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_phase"}, longint'(phase_inc), 0);
    check_eq({tag, "_busy"}, longint'(busy), 0);
    check_eq({tag, "_done"}, longint'(done), 0);
    check_eq({tag, "_valid"}, longint'(res_valid), 0);
    check_eq({tag, "_index"}, longint'(res_index), 0);
    check_eq({tag, "_sumx"}, longint'(res_sum_x), 0);
    check_eq({tag, "_sumy"}, longint'(res_sum_y), 0);
  endtask

  // Random traffic while busy: samples, stray starts and config changes must all be ignored.
  task automatic scramble(input int ce_pct);
    sample_ce     = ($urandom_range(99) < ce_pct);
    sample_x      = fix_en ? fix_x : DW'($urandom);
    sample_y      = fix_en ? fix_y : DW'($urandom);
    start         = $urandom_range(1);
    abort         = 1'b0;
    cfg_start_inc = PW'($urandom);
    cfg_step_inc  = PW'($urandom);
    cfg_num_steps = 16'($urandom);
    cfg_settle    = CNT_W'($urandom);
    cfg_dwell     = 16'($urandom);
  endtask

  task automatic quiet();
    start = 1'b0; abort = 1'b0; sample_ce = 1'b0; res_ready = 1'b0;
  endtask

  task automatic run_sweep(input logic [PW-1:0] s_inc, input logic [PW-1:0] st_inc,
                           input int n, input int settle, input int dwell, input int ce_pct,
                           input int max_bp, input int abort_step, input int reset_step);
    logic [PW-1:0] ph;
    longint sx, sy;
    int cnt, eff, bp, guard;
    bit first;
    eff = (dwell == 0) ? 1 : dwell;
    quiet();
    cfg_start_inc = s_inc; cfg_step_inc = st_inc; cfg_num_steps = 16'(n);
    cfg_settle = CNT_W'(settle); cfg_dwell = 16'(dwell);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      check_eq("zero_done", longint'(done), 1);
      check_eq("zero_busy", longint'(busy), 0);
      tick();
      check_eq("zero_done_pulse", longint'(done), 0);
      check_eq("zero_busy2", longint'(busy), 0);
      return;
    end
    check_eq("start_busy", longint'(busy), 1);
    check_eq("start_phase", longint'(phase_inc), longint'(s_inc));
    ph = s_inc;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c <= settle; c++) begin
        scramble(ce_pct);
        tick();
        check_eq("settle_valid", longint'(res_valid), 0);
      end
      sx = 0; sy = 0; cnt = 0; guard = 0; first = 1'b1;
      while (1) begin
        scramble(ce_pct);
        if (k == abort_step && first) begin
          sample_ce = 1'b0; abort = 1'b1;
          tick();
          quiet();
          check_eq("abort_busy", longint'(busy), 0);
          check_eq("abort_valid", longint'(res_valid), 0);
          check_eq("abort_done", longint'(done), 0);
          check_eq("abort_phase", longint'(phase_inc), longint'(ph));
          tick();
          check_eq("abort_done2", longint'(done), 0);
          check_eq("abort_idle", longint'(busy), 0);
          return;
        end
        first = 1'b0;
        if (sample_ce) begin
          sx += longint'(sample_x); sy += longint'(sample_y); cnt++;
        end
        tick();
        if (cnt == eff) break;
        check_eq("accum_valid", longint'(res_valid), 0);
        guard++;
        if (guard > 70000) begin
          check_eq("accum_timeout", longint'(guard), 0);
          quiet();
          return;
        end
      end
      start = 1'b0;
      check_eq("res_valid", longint'(res_valid), 1);
      check_eq("res_index", longint'(res_index), longint'(k));
      check_eq("res_sum_x", longint'($signed(res_sum_x)), sx);
      check_eq("res_sum_y", longint'($signed(res_sum_y)), sy);
      check_eq("res_phase", longint'(phase_inc), longint'(ph));
      if (k == reset_step) begin
        quiet();
        i_reset = 1'b1;
        tick();
        check_reset_vals("midrep_rst");
        i_reset = 1'b0;
        tick();
        check_reset_vals("post_rst");
        return;
      end
      bp = (max_bp == 0) ? 0 : $urandom_range(max_bp, max_bp / 2);
      for (int b = 0; b < bp; b++) begin
        scramble(ce_pct);
        res_ready = 1'b0;
        tick();
        check_eq("bp_valid", longint'(res_valid), 1);
        check_eq("bp_sum_x", longint'($signed(res_sum_x)), sx);
        check_eq("bp_sum_y", longint'($signed(res_sum_y)), sy);
        check_eq("bp_index", longint'(res_index), longint'(k));
        check_eq("bp_phase", longint'(phase_inc), longint'(ph));
      end
      scramble(ce_pct);
      res_ready = 1'b1;
      tick();
      quiet();
      check_eq("xfer_valid", longint'(res_valid), 0);
      if (k == n - 1) begin
        check_eq("final_done", longint'(done), 1);
        check_eq("final_busy", longint'(busy), 0);
      end else begin
        ph = ph + st_inc;
        check_eq("step_phase", longint'(phase_inc), longint'(ph));
        check_eq("step_busy", longint'(busy), 1);
        check_eq("step_done", longint'(done), 0);
      end
    end
    tick();
    check_eq("done_pulse", longint'(done), 0);
    check_eq("idle_busy", longint'(busy), 0);
    check_eq("idle_phase", longint'(phase_inc), longint'(ph));
  endtask

  initial begin
    i_reset = 1'b1;
    quiet();
    cfg_start_inc = '0; cfg_step_inc = '0; cfg_num_steps = '0; cfg_settle = '0; cfg_dwell = '0;
    sample_x = '0; sample_y = '0;
    tick(); tick();
    check_reset_vals("reset");
    i_reset = 1'b0;
    tick();
    check_reset_vals("reset_idle");

    // Basic sweep with constant samples.
    fix_en = 1'b1; fix_x = 16'sd100; fix_y = -16'sd50;
    run_sweep(19'h01000, 19'h00100, 3, 4, 2, 25, 0, -1, -1);
    fix_en = 1'b0;

    // Backpressure.
    run_sweep(PW'($urandom), PW'($urandom), 3, 2, 3, 50, 12, -1, -1);

    // Phase wrap-around.
    run_sweep(19'h7FF00, 19'h00200, 2, 1, 1, 60, 2, -1, -1);

    // Extreme dwell with full-scale negative samples.
    fix_en = 1'b1; fix_x = -16'sd32768; fix_y = -16'sd32768;
    run_sweep(PW'($urandom), PW'($urandom), 1, 0, 65535, 100, 0, -1, -1);
    fix_en = 1'b0;

    // Abort during ACCUM of step 1, then a clean sweep.
    run_sweep(19'h01000, 19'h00100, 3, 2, 3, 50, 2, 1, -1);
    run_sweep(PW'($urandom), PW'($urandom), 2, 1, 2, 50, 3, -1, -1);

    // Degenerate configurations.
    run_sweep(PW'($urandom), PW'($urandom), 0, 3, 3, 50, 0, -1, -1);
    run_sweep(PW'($urandom), PW'($urandom), 2, 0, 0, 40, 2, -1, -1);
    quiet();
    cfg_num_steps = 16'd3; cfg_settle = CNT_W'(2); cfg_dwell = 16'd2;
    cfg_start_inc = 19'h0ABCD;
    start = 1'b1; abort = 1'b1;
    tick();
    quiet();
    check_eq("sa_busy", longint'(busy), 0);
    check_eq("sa_done", longint'(done), 0);
    tick();
    check_eq("sa_busy2", longint'(busy), 0);

    // Reset while a result is pending, then a fresh sweep.
    run_sweep(PW'($urandom), PW'($urandom), 3, 1, 2, 50, 2, -1, 1);
    run_sweep(PW'($urandom), PW'($urandom), 2, 2, 2, 50, 2, -1, -1);

    for (int i = 0; i < 15; i++) begin
      run_sweep(PW'($urandom), PW'($urandom), $urandom_range(4), $urandom_range(6),
                $urandom_range(5), $urandom_range(90, 25), $urandom_range(6), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/phase_sweep_ctrl.md
# phase_sweep_ctrl

Sequencer for the downconversion local oscillator in the ADC→CORDIC→decimator→interpolator→CORDIC→DAC chain. It steps the NCO phase increment through a programmed frequency sweep and waits a settle time after each step so the decimation filters flush. It then integrates a programmed number of decimated I/Q samples and presents each step's sums to a downstream consumer over a valid/ready handshake. Its `phase_inc` output drives both phase accumulators, so the upconverter tracks the same frequency.

## Interface
Parameters:
- `PW`, 19: phase/increment width; matches the downconversion CORDIC phase width.
- `DW`, 16: decimated sample width (signed).
- `CNT_W`, 24: settle counter width.
- `ACC_W`, 32: accumulator width; must be ≥ `DW`+16 so that no overflow is possible.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `abort`  in  1  terminates the sweep; honoured in every state.
- `cfg_start_inc`  in  PW  first phase increment.
- `cfg_step_inc`  in  PW  increment added per step, modulo 2^PW.
- `cfg_num_steps`  in  16  number of steps in the sweep.
- `cfg_settle`  in  CNT_W  settle cycles per step.
- `cfg_dwell`  in  16  samples integrated per step.
- `sample_ce`  in  1  decimator output strobe (`ce_out`).
- `sample_x`, `sample_y`  in  DW  signed decimated I/Q.
- `phase_inc`  out  PW  current NCO increment.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes normally.
- `res_valid`  out  1  result handshake valid.
- `res_ready`  in  1  result handshake ready.
- `res_index`  out  16  step number of the presented result.
- `res_sum_x`, `res_sum_y`  out  ACC_W  signed sums.

## Operation
- States: IDLE, SETTLE, ACCUM, REPORT.
- The `cfg_*` inputs are latched on an accepted `start`. Later changes have no effect until the next sweep.
- **IDLE**
  - On `start` with `abort`=0 and `cfg_num_steps`≠0: load `phase_inc`←`cfg_start_inc`, index←0, settle counter←`cfg_settle`, go to SETTLE.
  - On `start` with `cfg_num_steps`=0: pulse `done` next cycle, stay in IDLE, produce no results.
- **SETTLE**
  - If the counter is 0, clear both accumulators and the sample count, then go to ACCUM.
  - Otherwise decrement the counter.
  - `sample_ce` is ignored in this state.
- **ACCUM**
  - On each `sample_ce`, add the sign-extended `sample_x` and `sample_y` to the accumulators and increment the sample count.
  - The sample that brings the count to the effective dwell is included; then go to REPORT.
  - Effective dwell is `max(cfg_dwell, 1)`.
- **REPORT**
  - `res_valid`=1. `res_sum_*` and `res_index` stay stable until the transfer.
  - On `res_valid`&`res_ready`:
    - If index = `cfg_num_steps`−1: go to IDLE and pulse `done`.
    - Otherwise: index++, `phase_inc` += `cfg_step_inc` (wrapping), reload the settle counter, go to SETTLE.
- **abort**, in any non-IDLE state: next cycle go to IDLE, `busy`=0, `res_valid`=0, no `done` pulse. A pending result is dropped. `phase_inc` holds its value.
- **`start` and `abort` in the same cycle in IDLE:** `abort` wins and the block stays in IDLE.
- **`start` while busy:** ignored.
- **Reset values:** state IDLE; `phase_inc`=0, `busy`=0, `done`=0, `res_valid`=0, `res_index`=0, `res_sum_x`=0, `res_sum_y`=0.
- **Reset mid-sweep:** same values on the next edge, regardless of the handshake state.

## Timing
- `start` accepted at cycle T: `busy`=1 and the new `phase_inc` appear at T+1.
- SETTLE occupies `cfg_settle`+1 cycles.
- ACCUM accepts samples from its first cycle.
- Last dwell sample at cycle S: `res_valid`=1 at S+1.
- Transfer at cycle R:
  - `res_valid`=0 at R+1.
  - The next `phase_inc` appears at R+1, or `done`=1 and `busy`=0 at R+1 for the final step.
- `abort` at cycle A: `busy`=0 at A+1.
- All outputs are registered.

## Test plan
- **Basic sweep:** start=0x1000, step=0x0100, steps=3, settle=4, dwell=2, `sample_ce` every 4th cycle with x=100, y=−50, `res_ready`=1 → three results, index 0/1/2, sums 200/−100. `phase_inc` reads 0x1000, 0x1100, 0x1200. `done` pulses once; SETTLE measures 5 cycles per step.
- **Backpressure:** hold `res_ready`=0 for 10 cycles in REPORT → `res_valid` and the sums stay stable, `phase_inc` unchanged, incoming `sample_ce` ignored. The transfer completes on the first ready cycle.
- **Wrap-around and extremes:** start=0x7FF00, step=0x00200, steps=2, dwell=65535 with x=y=−32768 → second `phase_inc` is 0x00100. Sums are −2147450880 with no overflow.
- **Abort:** `abort` during ACCUM of step 1 → IDLE next cycle, no result for step 1, no `done`, `phase_inc` holds. A fresh `start` runs normally.
- **Degenerate config:** steps=0 → `done` at T+1, `busy` never asserts. dwell=0 behaves as dwell=1. `start` and `abort` together → nothing happens.
- **Reset mid-REPORT:** `i_reset` asserted with `res_valid`=1 → all outputs return to reset values on the next edge and a new sweep starts cleanly.
